or1200_dual_operandmuxes: RTL and testbench
===========================================

OR1200_DUAL_OPERANDMUXES -- requirements
Module: or1200_dual_operandmuxes

Interface
REQ-001 The block SHALL have parameter dw, default 32, operand width.
REQ-002 The block SHALL have parameter aw, default 5, register address width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low (rst=0 resets on the next rising clk edge).
REQ-005 id_freeze, ex_freeze, flushpipe  input  1 each  pipeline hold and flush controls.
REQ-006 rf_dataa, rf_datab, rf_dataa2, rf_datab2  input  dw each  register file read data, lane 1 and lane 2.
REQ-007 id_addra, id_addrb, id_addra2, id_addrb2  input  aw each  source register addresses of the ID-stage pair.
REQ-008 id_simm, id_simm2  input  dw each; id_sel_imm, id_sel_imm2  input  1 each  immediates and B-operand immediate selects.
REQ-009 ex_we, ex_we2  input  1; ex_addrw, ex_addrw2  input  aw; ex_result, ex_result2  input  dw  EX-stage forwarding sources.
REQ-010 wb_we, wb_we2  input  1; wb_addrw, wb_addrw2  input  aw; wb_dataw, wb_dataw2  input  dw  WB-stage forwarding sources (same values driven to RF write ports).
REQ-011 operand_a, operand_b, operand_a2, operand_b2  output  dw each  registered EX-stage operands.
REQ-012 ex_valid  output  1  the EX operand pair holds a real instruction (0 = bubble).

Function
REQ-013 Live mux per operand SHALL select, in priority order: address 0 -> 0; ex_we2 hit -> ex_result2; ex_we hit -> ex_result; wb_we2 hit -> wb_dataw2; wb_we hit -> wb_dataw; else RF data. A hit is we=1 with a matching address.
REQ-014 Lane 2 SHALL win over lane 1 at the same stage (lane 2 is younger); EX SHALL win over WB.
REQ-015 For B operands, id_sel_imm / id_sel_imm2 = 1 SHALL select the immediate, bypassing forwarding and the saved value.
REQ-016 Each of the 4 operands SHALL have a saved register and a saved_valid flag.
REQ-017 Held cycle (id_freeze=1): saved SHALL load the live mux value when saved_valid=0 or any EX/WB hit exists for that operand; saved_valid SHALL be set to 1.
REQ-018 Effective value SHALL be the saved value when saved_valid=1 and the live mux value otherwise.
REQ-019 ex_freeze=0 and id_freeze=0: operands SHALL load the effective values, ex_valid SHALL become 1, and all saved_valid SHALL clear.
REQ-020 ex_freeze=0 and id_freeze=1: operands SHALL load 0 and ex_valid SHALL become 0 (bubble); the saved registers update per REQ-017.
REQ-021 ex_freeze=1: operands and ex_valid SHALL hold; saved registers update per REQ-017. ex_freeze=1 with id_freeze=0 SHALL be treated as id_freeze=1.
REQ-022 Latency: ID operand to output SHALL be exactly 1 clock when not frozen.
REQ-023 Intra-pair dependency (lane 2 reading lane 1's destination in the same ID pair) is excluded by the issue logic and SHALL NOT be forwarded.
REQ-024 flushpipe=1 SHALL, at the next edge, clear all operands, ex_valid and saved_valid, overriding both freezes.
REQ-025 Producers SHALL assert ex_we/ex_we2 only when the result is final.

Reset
REQ-026 rst=0 at an edge SHALL clear operand_a, operand_b, operand_a2, operand_b2 to 0, ex_valid to 0, and all saved registers and saved_valid flags to 0, overriding flushpipe and both freezes.
REQ-027 Reset asserted mid-hold SHALL discard saved values; the first post-reset unfrozen edge SHALL use the live mux.

Verification
REQ-028 RF only: id_addra=1 and rf_dataa=0x12345678, id_addra2=2 and rf_dataa2=0x90ABCDEF, no hits, freezes 0 -> next cycle operand_a=0x12345678, operand_a2=0x90ABCDEF, ex_valid=1.
REQ-029 Priority: id_addrb=13; ex_we=1 with ex_addrw=13 and ex_result=0x11; ex_we2=1 with ex_addrw2=13 and ex_result2=0x22; wb_we=1 with wb_addrw=13 -> operand_b=0x22. Repeat with ex_we2=0 -> 0x11.
REQ-030 r0 and immediate: id_addra=0 with ex_we=1 and ex_addrw=0 -> operand_a=0; id_sel_imm2=1 with id_simm2=0x0ABCDEF1 and a hit on id_addrb2 -> operand_b2=0x0ABCDEF1.
REQ-031 Hold capture: id_freeze=1 for 3 cycles while wb_we=1, wb_addrw=14, wb_dataw=0x23456789 in cycle 1 only, and rf_datab2 remains stale -> outputs 0 and ex_valid=0 during the hold; at release operand_b2=0x23456789 (id_addrb2=14).
REQ-032 ex_freeze=1 for 2 cycles -> outputs unchanged. flushpipe=1 during the hold -> all outputs 0; the next unfrozen edge uses the live mux.
REQ-033 rst=0 mid-hold with saved values present -> all outputs 0 at the next edge; after release, outputs follow REQ-028 values.

Source files
------------

// File: rtl/or1200_dual_operandmuxes_if.sv
// Operand-mux bus for the dual-issue pipeline.
// Carries the ID-stage operand sources, the EX/WB forwarding sources, the pipeline
// hold/flush controls and the registered EX-stage operands back out.
//   master : pipeline control side (drives sources, receives operands)
//   slave  : the operand mux block
interface or1200_dual_operandmuxes_if #(
    parameter int unsigned dw = 32,
    parameter int unsigned aw = 5
);
    // Pipeline controls
    logic          id_freeze;
    logic          ex_freeze;
    logic          flushpipe;
    // Register file read data, lane 1 / lane 2
    logic [dw-1:0] rf_dataa;
    logic [dw-1:0] rf_datab;
    logic [dw-1:0] rf_dataa2;
    logic [dw-1:0] rf_datab2;
    // ID-stage source addresses and immediates
    logic [aw-1:0] id_addra;
    logic [aw-1:0] id_addrb;
    logic [aw-1:0] id_addra2;
    logic [aw-1:0] id_addrb2;
    logic [dw-1:0] id_simm;
    logic [dw-1:0] id_simm2;
    logic          id_sel_imm;
    logic          id_sel_imm2;
    // EX-stage forwarding sources
    logic          ex_we;
    logic          ex_we2;
    logic [aw-1:0] ex_addrw;
    logic [aw-1:0] ex_addrw2;
    logic [dw-1:0] ex_result;
    logic [dw-1:0] ex_result2;
    // WB-stage forwarding sources
    logic          wb_we;
    logic          wb_we2;
    logic [aw-1:0] wb_addrw;
    logic [aw-1:0] wb_addrw2;
    logic [dw-1:0] wb_dataw;
    logic [dw-1:0] wb_dataw2;
    // Registered EX-stage operands
    logic [dw-1:0] operand_a;
    logic [dw-1:0] operand_b;
    logic [dw-1:0] operand_a2;
    logic [dw-1:0] operand_b2;
    logic          ex_valid;

    modport master (
        output id_freeze, ex_freeze, flushpipe,
        output rf_dataa, rf_datab, rf_dataa2, rf_datab2,
        output id_addra, id_addrb, id_addra2, id_addrb2,
        output id_simm, id_simm2, id_sel_imm, id_sel_imm2,
        output ex_we, ex_we2, ex_addrw, ex_addrw2, ex_result, ex_result2,
        output wb_we, wb_we2, wb_addrw, wb_addrw2, wb_dataw, wb_dataw2,
        input  operand_a, operand_b, operand_a2, operand_b2, ex_valid
    );

    modport slave (
        input  id_freeze, ex_freeze, flushpipe,
        input  rf_dataa, rf_datab, rf_dataa2, rf_datab2,
        input  id_addra, id_addrb, id_addra2, id_addrb2,
        input  id_simm, id_simm2, id_sel_imm, id_sel_imm2,
        input  ex_we, ex_we2, ex_addrw, ex_addrw2, ex_result, ex_result2,
        input  wb_we, wb_we2, wb_addrw, wb_addrw2, wb_dataw, wb_dataw2,
        output operand_a, operand_b, operand_a2, operand_b2, ex_valid
    );
endinterface

// File: rtl/or1200_dual_operandmuxes.sv
// Dual-issue operand muxes with EX/WB forwarding and freeze-safe capture.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-low reset
//   bus  : operand-mux bus (slave side) -- sources, forwarding, controls, EX operands
// Operand index: 0 = A, 1 = B, 2 = A2, 3 = B2.
module or1200_dual_operandmuxes #(
    parameter int unsigned dw = 32,
    parameter int unsigned aw = 5
) (
    input logic                         clk,
    input logic                         rst,
    or1200_dual_operandmuxes_if.slave   bus
);

    logic [aw-1:0] src_addr [4];
    logic [dw-1:0] src_rf   [4];
    logic [dw-1:0] src_imm  [4];
    logic          src_sel  [4];

    logic [dw-1:0] live     [4];
    logic [dw-1:0] eff      [4];
    logic          fwd_hit  [4];

    logic [dw-1:0] operand_q [4];
    logic [dw-1:0] operand_d [4];
    logic [dw-1:0] saved_q   [4];
    logic [dw-1:0] saved_d   [4];
    logic [3:0]    saved_valid_q;
    logic [3:0]    saved_valid_d;
    logic          ex_valid_q;
    logic          ex_valid_d;
    logic          held;

    // Gather per-operand sources; A operands never take an immediate.
    always_comb begin
        src_addr[0] = bus.id_addra;
        src_addr[1] = bus.id_addrb;
        src_addr[2] = bus.id_addra2;
        src_addr[3] = bus.id_addrb2;
        src_rf[0]   = bus.rf_dataa;
        src_rf[1]   = bus.rf_datab;
        src_rf[2]   = bus.rf_dataa2;
        src_rf[3]   = bus.rf_datab2;
        src_imm[0]  = '0;
        src_imm[1]  = bus.id_simm;
        src_imm[2]  = '0;
        src_imm[3]  = bus.id_simm2;
        src_sel[0]  = 1'b0;
        src_sel[1]  = bus.id_sel_imm;
        src_sel[2]  = 1'b0;
        src_sel[3]  = bus.id_sel_imm2;
    end

    // Live mux: r0, then younger producers first (EX lane 2, EX lane 1, WB lane 2, WB lane 1).
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            logic h_ex2, h_ex1, h_wb2, h_wb1;
            logic [dw-1:0] fwd;
            h_ex2 = bus.ex_we2 && (bus.ex_addrw2 == src_addr[i]);
            h_ex1 = bus.ex_we  && (bus.ex_addrw  == src_addr[i]);
            h_wb2 = bus.wb_we2 && (bus.wb_addrw2 == src_addr[i]);
            h_wb1 = bus.wb_we  && (bus.wb_addrw  == src_addr[i]);
            fwd_hit[i] = h_ex2 | h_ex1 | h_wb2 | h_wb1;
            if (src_addr[i] == '0)  fwd = '0;
            else if (h_ex2)         fwd = bus.ex_result2;
            else if (h_ex1)         fwd = bus.ex_result;
            else if (h_wb2)         fwd = bus.wb_dataw2;
            else if (h_wb1)         fwd = bus.wb_dataw;
            else                    fwd = src_rf[i];
            live[i] = src_sel[i] ? src_imm[i] : fwd;
            // The immediate bypasses the saved copy too.
            if (src_sel[i])             eff[i] = src_imm[i];
            else if (saved_valid_q[i])  eff[i] = saved_q[i];
            else                        eff[i] = live[i];
        end
    end

    // ex_freeze alone still stalls ID, so it counts as a hold for capture.
    assign held = bus.id_freeze | bus.ex_freeze;

    always_comb begin
        operand_d     = operand_q;
        saved_d       = saved_q;
        saved_valid_d = saved_valid_q;
        ex_valid_d    = ex_valid_q;
        if (bus.flushpipe) begin
            for (int i = 0; i < 4; i++) begin
                operand_d[i] = '0;
                saved_d[i]   = '0;
            end
            saved_valid_d = '0;
            ex_valid_d    = 1'b0;
        end else begin
            if (held) begin
                // Capture once, then refresh only when a producer writes our source,
                // since the RF read data goes stale while held.
                for (int i = 0; i < 4; i++) begin
                    if (!saved_valid_q[i] || fwd_hit[i]) saved_d[i] = live[i];
                end
                saved_valid_d = '1;
            end else begin
                saved_valid_d = '0;
            end
            if (!bus.ex_freeze) begin
                if (!bus.id_freeze) begin
                    operand_d  = eff;
                    ex_valid_d = 1'b1;
                end else begin
                    for (int i = 0; i < 4; i++) operand_d[i] = '0;
                    ex_valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                operand_q[i] <= '0;
                saved_q[i]   <= '0;
            end
            saved_valid_q <= '0;
            ex_valid_q    <= 1'b0;
        end else begin
            operand_q     <= operand_d;
            saved_q       <= saved_d;
            saved_valid_q <= saved_valid_d;
            ex_valid_q    <= ex_valid_d;
        end
    end

    assign bus.operand_a  = operand_q[0];
    assign bus.operand_b  = operand_q[1];
    assign bus.operand_a2 = operand_q[2];
    assign bus.operand_b2 = operand_q[3];
    assign bus.ex_valid   = ex_valid_q;

endmodule

// File: tb/tb_or1200_dual_operandmuxes.sv
// Directed-vector bench for or1200_dual_operandmuxes.
module tb_or1200_dual_operandmuxes;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec  = 0;
    int   n_miss = 0;

    or1200_dual_operandmuxes_if #(.dw(32), .aw(5)) bus ();

    or1200_dual_operandmuxes #(.dw(32), .aw(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle past it before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fwd();
        bus.ex_we = 0; bus.ex_we2 = 0; bus.wb_we = 0; bus.wb_we2 = 0;
        bus.ex_addrw = 0; bus.ex_addrw2 = 0; bus.wb_addrw = 0; bus.wb_addrw2 = 0;
        bus.ex_result = 0; bus.ex_result2 = 0; bus.wb_dataw = 0; bus.wb_dataw2 = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_a"},  bus.operand_a,  32'h0);
        check_eq({tag, "_b"},  bus.operand_b,  32'h0);
        check_eq({tag, "_a2"}, bus.operand_a2, 32'h0);
        check_eq({tag, "_b2"}, bus.operand_b2, 32'h0);
        check_eq({tag, "_v"},  {31'h0, bus.ex_valid}, 32'h0);
    endtask

    task automatic set_rf_basic();
        bus.id_addra = 5'd1;  bus.rf_dataa  = 32'h12345678;
        bus.id_addra2 = 5'd2; bus.rf_dataa2 = 32'h90ABCDEF;
        bus.id_addrb = 5'd3;  bus.rf_datab  = 32'h00000033;
        bus.id_addrb2 = 5'd4; bus.rf_datab2 = 32'h00000044;
        bus.id_sel_imm = 0; bus.id_sel_imm2 = 0;
    endtask

    initial begin
        bus.id_freeze = 0; bus.ex_freeze = 0; bus.flushpipe = 0;
        bus.id_simm = 0; bus.id_simm2 = 0;
        clear_fwd();
        set_rf_basic();

        // Reset state
        tick(); tick();
        check_all_zero("reset");

        // RF-only path
        rst = 1;
        tick();
        check_eq("rf_a",  bus.operand_a,  32'h12345678);
        check_eq("rf_a2", bus.operand_a2, 32'h90ABCDEF);
        check_eq("rf_b",  bus.operand_b,  32'h00000033);
        check_eq("rf_b2", bus.operand_b2, 32'h00000044);
        check_eq("rf_v",  {31'h0, bus.ex_valid}, 32'h1);

        // Forwarding priority on B
        bus.id_addrb = 5'd13;
        bus.ex_we = 1;  bus.ex_addrw = 5'd13;  bus.ex_result = 32'h11;
        bus.ex_we2 = 1; bus.ex_addrw2 = 5'd13; bus.ex_result2 = 32'h22;
        bus.wb_we = 1;  bus.wb_addrw = 5'd13;  bus.wb_dataw = 32'h66;
        bus.wb_we2 = 1; bus.wb_addrw2 = 5'd13; bus.wb_dataw2 = 32'h55;
        tick();
        check_eq("pri_ex2", bus.operand_b, 32'h22);
        bus.ex_we2 = 0;
        tick();
        check_eq("pri_ex1", bus.operand_b, 32'h11);
        bus.ex_we = 0;
        tick();
        check_eq("pri_wb2", bus.operand_b, 32'h55);
        bus.wb_we2 = 0;
        tick();
        check_eq("pri_wb1", bus.operand_b, 32'h66);
        clear_fwd();

        // r0 and immediate
        bus.id_addra = 5'd0;
        bus.ex_we = 1; bus.ex_addrw = 5'd0; bus.ex_result = 32'h99;
        bus.id_sel_imm2 = 1; bus.id_simm2 = 32'h0ABCDEF1; bus.id_addrb2 = 5'd13;
        bus.ex_we2 = 1; bus.ex_addrw2 = 5'd13; bus.ex_result2 = 32'h77;
        tick();
        check_eq("r0_a",  bus.operand_a,  32'h0);
        check_eq("imm_b2", bus.operand_b2, 32'h0ABCDEF1);
        clear_fwd();
        set_rf_basic();

        // Hold capture of a one-cycle WB result
        bus.id_addrb2 = 5'd14; bus.rf_datab2 = 32'hDEAD0000;
        bus.id_freeze = 1;
        bus.wb_we = 1; bus.wb_addrw = 5'd14; bus.wb_dataw = 32'h23456789;
        tick();
        check_eq("hold1_b2", bus.operand_b2, 32'h0);
        check_eq("hold1_v",  {31'h0, bus.ex_valid}, 32'h0);
        clear_fwd();
        tick();
        check_eq("hold2_b2", bus.operand_b2, 32'h0);
        tick();
        check_eq("hold3_b2", bus.operand_b2, 32'h0);
        bus.id_freeze = 0;
        tick();
        check_eq("rel_b2", bus.operand_b2, 32'h23456789);
        check_eq("rel_v",  {31'h0, bus.ex_valid}, 32'h1);
        tick();
        check_eq("post_b2", bus.operand_b2, 32'hDEAD0000);

        // ex_freeze holds outputs and still captures live ID values
        set_rf_basic();
        tick();
        check_eq("pre_exf_a", bus.operand_a, 32'h12345678);
        bus.ex_freeze = 1; bus.rf_dataa = 32'h77777777;
        tick();
        check_eq("exf1_a", bus.operand_a, 32'h12345678);
        check_eq("exf1_v", {31'h0, bus.ex_valid}, 32'h1);
        bus.rf_dataa = 32'h88888888;
        tick();
        check_eq("exf2_a", bus.operand_a, 32'h12345678);
        bus.ex_freeze = 0;
        tick();
        check_eq("exf_rel_a", bus.operand_a, 32'h77777777);

        // Flush during a hold drops the saved copy
        bus.id_freeze = 1;
        bus.wb_we = 1; bus.wb_addrw = 5'd1; bus.wb_dataw = 32'hAAAAAAAA;
        tick();
        clear_fwd();
        bus.flushpipe = 1;
        tick();
        check_all_zero("flush");
        bus.flushpipe = 0; bus.id_freeze = 0; bus.rf_dataa = 32'h31313131;
        tick();
        check_eq("flush_live_a", bus.operand_a, 32'h31313131);
        check_eq("flush_live_v", {31'h0, bus.ex_valid}, 32'h1);

        // Reset mid-hold discards saved values
        bus.id_freeze = 1;
        bus.wb_we = 1; bus.wb_addrw = 5'd1; bus.wb_dataw = 32'hBBBBBBBB;
        tick();
        clear_fwd();
        rst = 0;
        tick();
        check_all_zero("rst_hold");
        rst = 1; bus.id_freeze = 0;
        set_rf_basic();
        tick();
        check_eq("rst_rel_a",  bus.operand_a,  32'h12345678);
        check_eq("rst_rel_a2", bus.operand_a2, 32'h90ABCDEF);
        check_eq("rst_rel_v",  {31'h0, bus.ex_valid}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
